// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared BCD digit width and 7-segment (gfedcba) glyph constants
package bcd_disp_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_bcd_dec.sv
// rtl/seg7_bcd_dec.sv - combinational BCD digit to active-high gfedcba segments with blanking
module seg7_bcd_dec
    import bcd_disp_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic             blank_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - prescaled N-digit up/down BCD counter with multiplexed 7-segment scan
module bcd_scan_counter
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int SCAN_DIV   = 10_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        run,
    input  logic                        up,
    input  logic                        clr,
    input  logic                        load,
    input  logic [NUM_DIGITS*BCD_W-1:0] load_bcd,
    output logic [NUM_DIGITS*BCD_W-1:0] count_bcd,
    output logic                        tick,
    output logic                        wrap,
    output logic [6:0]                  segments,
    output logic [NUM_DIGITS-1:0]       digit_sel
);

    localparam int CW     = NUM_DIGITS * BCD_W;
    localparam int PRE_W  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int SCAN_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

    logic [CW-1:0]         count_q, count_d, step_val, load_val;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick_q, tick_d, wrap_q, wrap_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  carry, lz_run, disp_blank;
    logic [BCD_W-1:0]      digit, nib, disp_bcd;
    logic [NUM_DIGITS-1:0] lead_zero;

    // Decimal increment/decrement: the carry/borrow keeps moving only past 9s (up) or 0s (down).
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        digit    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count_q[i*BCD_W +: BCD_W];
            if (carry) begin
                if (up) begin
                    if (digit == 4'd9) begin
                        step_val[i*BCD_W +: BCD_W] = 4'd0;
                    end else begin
                        step_val[i*BCD_W +: BCD_W] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        step_val[i*BCD_W +: BCD_W] = 4'd9;
                    end else begin
                        step_val[i*BCD_W +: BCD_W] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        load_val = '0;
        nib      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = load_bcd[i*BCD_W +: BCD_W];
            load_val[i*BCD_W +: BCD_W] = (nib > 4'd9) ? 4'd9 : nib;
        end
    end

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
            pre_d   = '0;
        end else if (load) begin
            count_d = load_val;
            pre_d   = '0;
        end else if (run) begin
            if (pre_q == PRE_MAX) begin
                pre_d   = '0;
                count_d = step_val;
                tick_d  = 1'b1;
                wrap_d  = carry;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_comb begin
        scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Display uses the pre-edge count so segments and digit_sel land together, one cycle behind.
    always_comb begin
        lead_zero  = '0;
        lz_run     = 1'b1;
        disp_bcd   = '0;
        disp_blank = 1'b0;
        sel_d      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run       = lz_run && (count_q[i*BCD_W +: BCD_W] == 4'd0);
            lead_zero[i] = lz_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_d[i]   = 1'b1;
                disp_bcd   = count_q[i*BCD_W +: BCD_W];
                disp_blank = (BLANK_LZ != 0) && (i != 0) && lead_zero[i];
            end
        end
    end

    seg7_bcd_dec u_dec (
        .bcd_i   (disp_bcd),
        .blank_i (disp_blank),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pre_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            seg_q   <= SEG_0;
            sel_q   <= NUM_DIGITS'(1);
        end else if (ena) begin
            count_q <= count_d;
            pre_q   <= pre_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign count_bcd = count_q;
    assign tick      = tick_q & ena;
    assign wrap      = wrap_q & ena;
    assign segments  = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst_n, ena, run, up, clr, load;
    logic [15:0] load_bcd;
    logic [15:0] count_bcd;
    logic        tick, wrap;
    logic [6:0]  segments;
    logic [3:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    bcd_scan_counter #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .SCAN_DIV   (2),
        .BLANK_LZ   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .run       (run),
        .up        (up),
        .clr       (clr),
        .load      (load),
        .load_bcd  (load_bcd),
        .count_bcd (count_bcd),
        .tick      (tick),
        .wrap      (wrap),
        .segments  (segments),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_check(input logic [15:0] val, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        int k;
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        run = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        load = 1'b1;
        load_bcd = val;
        cyc(1);
        load = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cyc(1);
            k = (j / 2 + 1) % 4;
            check_val("scan_sel", 32'(digit_sel), 32'(4'b0001 << k));
            check_val("scan_seg", 32'(segments), 32'(exp_seg[k]));
        end
        check_val("scan_hold", 32'(count_bcd), 32'(val));
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; run = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_bcd = '0;
        cyc(3);
        check_val("rst_count", 32'(count_bcd), 32'h0000);
        check_val("rst_sel", 32'(digit_sel), 32'h1);
        check_val("rst_seg", 32'(segments), 32'h3F);
        check_val("rst_tick", 32'(tick), 32'h0);
        check_val("rst_wrap", 32'(wrap), 32'h0);

        rst_n = 1'b1; run = 1'b1; up = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            check_val("up_tick", 32'(tick), 32'((i % 4) == 0));
            if (i == 36) check_val("up_0009", 32'(count_bcd), 32'h0009);
            if (i == 40) check_val("up_0010", 32'(count_bcd), 32'h0010);
        end

        cyc(2);
        rst_n = 1'b0;
        #1;
        check_val("async_count", 32'(count_bcd), 32'h0000);
        check_val("async_sel", 32'(digit_sel), 32'h1);
        check_val("async_seg", 32'(segments), 32'h3F);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_val("rst_low_tick", 32'(tick), 32'h0);
        end
        rst_n = 1'b1;
        cyc(1);
        check_val("post_rst_tick", 32'(tick), 32'h0);
        check_val("post_rst_count", 32'(count_bcd), 32'h0000);

        load_bcd = 16'h9998; load = 1'b1;
        cyc(1);
        load = 1'b0;
        check_val("load_9998", 32'(count_bcd), 32'h9998);
        check_val("load_no_tick", 32'(tick), 32'h0);
        cyc(3);
        check_val("hold_9998", 32'(count_bcd), 32'h9998);
        cyc(1);
        check_val("up_9999", 32'(count_bcd), 32'h9999);
        check_val("up_9999_wrap", 32'(wrap), 32'h0);
        cyc(4);
        check_val("up_wrap_0000", 32'(count_bcd), 32'h0000);
        check_val("up_wrap", 32'(wrap), 32'h1);
        check_val("up_wrap_tick", 32'(tick), 32'h1);
        cyc(1);
        check_val("up_wrap_pulse", 32'(wrap), 32'h0);

        up = 1'b0; load_bcd = 16'h0001; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(4);
        check_val("dn_0000", 32'(count_bcd), 32'h0000);
        check_val("dn_0000_wrap", 32'(wrap), 32'h0);
        cyc(4);
        check_val("dn_9999", 32'(count_bcd), 32'h9999);
        check_val("dn_wrap", 32'(wrap), 32'h1);

        run = 1'b0; load_bcd = 16'hFA32; load = 1'b1;
        cyc(1);
        check_val("load_sat", 32'(count_bcd), 32'h9932);
        clr = 1'b1; load_bcd = 16'h1234;
        cyc(1);
        clr = 1'b0; load = 1'b0;
        check_val("clr_over_load", 32'(count_bcd), 32'h0000);
        check_val("clr_no_tick", 32'(tick), 32'h0);

        scan_check(16'h0042, 7'h5B, 7'h66, 7'h00, 7'h00);
        scan_check(16'h0402, 7'h5B, 7'h3F, 7'h66, 7'h00);

        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; run = 1'b1; up = 1'b1;
        cyc(2);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check_val("ena_tick", 32'(tick), 32'h0);
            check_val("ena_count", 32'(count_bcd), 32'h0000);
            check_val("ena_sel", 32'(digit_sel), 32'h2);
            check_val("ena_seg", 32'(segments), 32'h00);
        end
        ena = 1'b1;
        cyc(1);
        check_val("resume_no_tick", 32'(tick), 32'h0);
        cyc(1);
        check_val("resume_tick", 32'(tick), 32'h1);
        check_val("resume_count", 32'(count_bcd), 32'h0001);
        check_val("resume_sel", 32'(digit_sel), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
